// File: rtl/bc_buffer_pair.sv
// Bidirectional breadcrumb buffer: two independent first-word-fall-through FIFOs.
// Define BC_BUFFER_OVERWRITE_EN to drop the oldest entry on a write to a full FIFO.
module bc_buffer_pair #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AF_THRESH = 448,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] avoid_in_data,
  input  logic              avoid_in_valid,
  output logic              avoid_in_rdy,
  output logic [DATA_W-1:0] ctrl_out_data,
  output logic              ctrl_out_valid,
  input  logic              ctrl_out_rdy,
  input  logic [DATA_W-1:0] ctrl_in_data,
  input  logic              ctrl_in_valid,
  output logic              ctrl_in_rdy,
  output logic [DATA_W-1:0] avoid_out_data,
  output logic              avoid_out_valid,
  input  logic              avoid_out_rdy,
  input  logic              new_flush,
  input  logic              old_flush,
  output logic [CNT_W-1:0]  new_count,
  output logic [CNT_W-1:0]  old_count,
  output logic              new_almost_full,
  output logic              old_almost_full,
  output logic              new_overflow,
  output logic              old_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Index 0 is the new channel, index 1 the old channel.
  logic [DATA_W-1:0] in_data   [2];
  logic              in_valid  [2];
  logic              in_rdy    [2];
  logic [DATA_W-1:0] out_data  [2];
  logic              out_valid [2];
  logic              out_rdy   [2];
  logic              flush     [2];
  logic [CNT_W-1:0]  count     [2];
  logic              almost    [2];
  logic              ovf       [2];

  assign in_data[0]  = avoid_in_data;
  assign in_valid[0] = avoid_in_valid;
  assign out_rdy[0]  = ctrl_out_rdy;
  assign flush[0]    = new_flush;
  assign in_data[1]  = ctrl_in_data;
  assign in_valid[1] = ctrl_in_valid;
  assign out_rdy[1]  = avoid_out_rdy;
  assign flush[1]    = old_flush;

  assign avoid_in_rdy    = in_rdy[0];
  assign ctrl_out_data   = out_data[0];
  assign ctrl_out_valid  = out_valid[0];
  assign new_count       = count[0];
  assign new_almost_full = almost[0];
  assign new_overflow    = ovf[0];
  assign ctrl_in_rdy     = in_rdy[1];
  assign avoid_out_data  = out_data[1];
  assign avoid_out_valid = out_valid[1];
  assign old_count       = count[1];
  assign old_almost_full = almost[1];
  assign old_overflow    = ovf[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, push, pop, drop;

    assign full = (count_q == CNT_W'(DEPTH));

`ifdef BC_BUFFER_OVERWRITE_EN
    logic ovf_q, ovf_d;

    assign in_rdy[c] = rst && !flush[c];
    // A push into a full FIFO with no pop evicts the head.
    assign drop      = push && !pop && full;
    assign ovf_d     = flush[c] ? 1'b0 : (ovf_q | drop);
    assign ovf[c]    = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_d;
      end
    end
`else
    assign in_rdy[c] = rst && !flush[c] && !full;
    assign drop      = 1'b0;
    assign ovf[c]    = 1'b0;
`endif

    assign push = in_valid[c] && in_rdy[c];
    assign pop  = out_valid[c] && out_rdy[c] && !flush[c];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush[c]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop || drop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop && !full) begin
          count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_data[c];
    end

    assign out_valid[c] = (count_q != '0);
    assign out_data[c]  = out_valid[c] ? mem[rd_ptr_q] : '0;
    assign count[c]     = count_q;
    assign almost[c]    = (count_q >= CNT_W'(AF_THRESH));
  end

endmodule

// File: tb/tb_bc_buffer_pair.sv
// Randomised and directed bench for bc_buffer_pair against a queue-based reference model.
module tb_bc_buffer_pair;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef BC_BUFFER_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] in_data   [2];
  logic          in_valid  [2];
  logic          out_rdy   [2];
  logic          flush     [2];
  logic          in_rdy    [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic [CW-1:0] count     [2];
  logic          almost    [2];
  logic          ovf       [2];

  bc_buffer_pair #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .avoid_in_data  (in_data[0]),
    .avoid_in_valid (in_valid[0]),
    .avoid_in_rdy   (in_rdy[0]),
    .ctrl_out_data  (out_data[0]),
    .ctrl_out_valid (out_valid[0]),
    .ctrl_out_rdy   (out_rdy[0]),
    .ctrl_in_data   (in_data[1]),
    .ctrl_in_valid  (in_valid[1]),
    .ctrl_in_rdy    (in_rdy[1]),
    .avoid_out_data (out_data[1]),
    .avoid_out_valid(out_valid[1]),
    .avoid_out_rdy  (out_rdy[1]),
    .new_flush      (flush[0]),
    .old_flush      (flush[1]),
    .new_count      (count[0]),
    .old_count      (count[1]),
    .new_almost_full(almost[0]),
    .old_almost_full(almost[1]),
    .new_overflow   (ovf[0]),
    .old_overflow   (ovf[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue of stored words per channel, head at index 0.
  logic [DW-1:0] mq   [2][$];
  logic          movf [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int c = 0; c < 2; c++) begin
      in_data[c]  = '0;
      in_valid[c] = 1'b0;
      out_rdy[c]  = 1'b0;
      flush[c]    = 1'b0;
    end
  endtask

  function automatic bit model_rdy(int c);
    return rst && !flush[c] && (OVW || mq[c].size() < DEPTH);
  endfunction

  task automatic check_outputs();
    for (int c = 0; c < 2; c++) begin
      int sz = mq[c].size();
      logic [DW-1:0] head = (sz != 0) ? mq[c][0] : '0;
      check($sformatf("ch%0d_valid", c), 32'(out_valid[c]), 32'(sz != 0));
      check($sformatf("ch%0d_data", c), 32'(out_data[c]), 32'(head));
      check($sformatf("ch%0d_rdy", c), 32'(in_rdy[c]), 32'(model_rdy(c)));
      check($sformatf("ch%0d_count", c), 32'(count[c]), 32'(sz));
      check($sformatf("ch%0d_af", c), 32'(almost[c]), 32'(sz >= AF));
      check($sformatf("ch%0d_ovf", c), 32'(ovf[c]), 32'(OVW && movf[c]));
    end
  endtask

  // Inputs are set before calling; checks, clocks once and advances the model.
  task automatic step();
    bit push [2];
    bit pop  [2];
    #1;
    check_outputs();
    for (int c = 0; c < 2; c++) begin
      push[c] = in_valid[c] && model_rdy(c);
      pop[c]  = (mq[c].size() != 0) && out_rdy[c] && !flush[c];
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (flush[c]) begin
        mq[c].delete();
        movf[c] = 1'b0;
      end else begin
        if (pop[c]) void'(mq[c].pop_front());
        if (push[c]) begin
          if (mq[c].size() == DEPTH) begin
            void'(mq[c].pop_front());
            movf[c] = 1'b1;
          end
          mq[c].push_back(in_data[c]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic fill(int c, int n, int base);
    for (int i = 0; i < n; i++) begin
      in_valid[c] = 1'b1;
      in_data[c]  = DW'(base + i);
      step();
    end
    in_valid[c] = 1'b0;
  endtask

  task automatic drain(int c);
    out_rdy[c] = 1'b1;
    for (int i = 0; i < DEPTH + 2 && mq[c].size() != 0; i++) step();
    out_rdy[c] = 1'b0;
    check($sformatf("drain%0d_empty", c), 32'(out_valid[c]), 32'(0));
  endtask

  initial begin
    logic [DW-1:0] last;
    rst = 1'b0;
    idle();
    for (int c = 0; c < 2; c++) movf[c] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Single word latency and pop back to empty.
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h1234;
    step();
    in_valid[0] = 1'b0;
    #1;
    check("t1_data", 32'(out_data[0]), 32'h1234);
    check("t1_count", 32'(count[0]), 32'd1);
    out_rdy[0] = 1'b1;
    step();
    out_rdy[0] = 1'b0;
    step();
    check("t1_empty_data", 32'(out_data[0]), 32'h0);

    // Fill to full, then drain in order.
    fill(0, DEPTH, 0);
    #1;
    check("t2_rdy_full", 32'(in_rdy[0]), 32'(OVW));
    check("t2_count", 32'(count[0]), 32'(DEPTH));
    check("t2_af", 32'(almost[0]), 32'd1);
    out_rdy[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("t2_order", 32'(out_data[0]), 32'(i));
      step();
    end
    out_rdy[0] = 1'b0;
    step();

    // Full with simultaneous push and pop.
    fill(0, DEPTH, 0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h00AA;
    out_rdy[0]  = 1'b1;
    #1;
    check("t3_head", 32'(out_data[0]), 32'h0);
    step();
    out_rdy[0] = 1'b0;
    #1;
    check("t3_count", 32'(count[0]), OVW ? 32'(DEPTH) : 32'(DEPTH - 1));
    if (!OVW) step();
    in_valid[0] = 1'b0;
    out_rdy[0]  = 1'b1;
    last = '0;
    for (int i = 0; i < DEPTH + 2 && mq[0].size() != 0; i++) begin
      #1;
      last = out_data[0];
      step();
    end
    out_rdy[0] = 1'b0;
    check("t3_last", 32'(last), 32'h00AA);

`ifdef BC_BUFFER_OVERWRITE_EN
    // Overwrite drops the oldest entry and sets the sticky flag.
    fill(0, DEPTH, 0);
    fill(0, 1, DEPTH);
    #1;
    check("t4_ovf", 32'(ovf[0]), 32'd1);
    check("t4_head", 32'(out_data[0]), 32'd1);
    check("t4_count", 32'(count[0]), 32'(DEPTH));
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    #1;
    check("t4_flush_count", 32'(count[0]), 32'd0);
    check("t4_flush_ovf", 32'(ovf[0]), 32'd0);
`endif

    // Flush beats a same-cycle write.
    fill(0, 3, 16'h40);
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0077;
    step();
    idle();
    #1;
    check("t5_count", 32'(count[0]), 32'd0);
    check("t5_valid", 32'(out_valid[0]), 32'd0);
    step();

    // Asynchronous reset mid-stream on both channels.
    fill(0, 2, 16'h100);
    fill(1, 3, 16'h200);
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    out_rdy[1]  = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      movf[c] = 1'b0;
      check($sformatf("t6_valid%0d", c), 32'(out_valid[c]), 32'd0);
      check($sformatf("t6_rdy%0d", c), 32'(in_rdy[c]), 32'd0);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomised traffic on both channels.
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 2; c++) begin
        in_valid[c] = ($urandom_range(0, 3) != 0);
        in_data[c]  = DW'($urandom);
        out_rdy[c]  = ($urandom_range(0, 2) == 0) || (n % 200 > 150);
        flush[c]    = ($urandom_range(0, 40) == 0);
      end
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
